// File: rtl/matmul_seq_pkg.sv
// Shared types, FSM state encoding and the saturating accumulate used by
// matmul_seq and any block that consumes its results.
package matmul_seq_pkg;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam acc_t ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam acc_t ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // One extra bit catches overflow; the sign of the wide sum picks the rail.
  function automatic acc_t sat_add(input acc_t x, input acc_t y);
    logic [ACC_W:0] s;
    s = {x[ACC_W-1], x} + {y[ACC_W-1], y};
    if (s[ACC_W] != s[ACC_W-1]) return s[ACC_W] ? ACC_MIN : ACC_MAX;
    return acc_t'(s[ACC_W-1:0]);
  endfunction

endpackage

// File: rtl/matmul_seq_if.sv
// Initiator-side bus of matmul_seq: start/done handshake plus operand and result vectors.
interface matmul_seq_if #(
  parameter int K          = 16,
  parameter int N          = 64,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32
);
  // Handshake: start is a one-cycle pulse, honoured only while the block is
  // idle; busy covers the run, done pulses once; b_in stays stable until done.
  logic                                 start;
  logic [K-1:0][DATA_WIDTH-1:0]         a_in;
  logic [K*N-1:0][DATA_WIDTH-1:0]       b_in;
  logic [N-1:0][ACC_WIDTH-1:0]          c_out;
  logic                                 done;
  logic                                 busy;

  modport master (output start, a_in, b_in, input  c_out, done, busy);
  modport slave  (input  start, a_in, b_in, output c_out, done, busy);
endinterface

// File: rtl/matmul_seq_mac_lane.sv
// One MAC column: signed full-precision product folded into a saturating accumulator.
module mac_lane
  import matmul_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output acc_t                         acc
);
  acc_t prod;

  assign prod = acc_t'(a) * acc_t'(b);

  always_ff @(posedge clk) begin
    if (!rst_n)   acc <= '0;
    else if (clear) acc <= '0;
    else if (en)  acc <= sat_add(acc, prod);
  end
endmodule

// File: rtl/matmul_seq.sv
// Sequential vector x matrix product: LANES output columns per pass over K,
// N/LANES passes, saturating Q2.30 results latched group by group.
module matmul_seq
  import matmul_seq_pkg::*;
#(
  parameter int K          = 16,
  parameter int N          = 64,
  parameter int LANES      = 8,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  matmul_seq_if.slave  bus,
  output state_e       dbg_state
);
  localparam int G  = N / LANES;
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int IW = (K * N > 1) ? $clog2(K * N) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(K - 1);
  localparam logic [GW-1:0] G_LAST = GW'(G - 1);

  if ((N % LANES) != 0 || K < 1 || DATA_WIDTH != DATA_W || ACC_WIDTH != ACC_W) begin : g_bad_cfg
    $error("matmul_seq: illegal configuration");
  end

  state_e        state;
  logic [KW-1:0] k;
  logic [GW-1:0] g;
  data_t         a_reg [K];
  acc_t          c_reg [N];
  acc_t          lane_acc [LANES];
  logic          lane_clear;
  logic          lane_en;

  assign lane_clear = (state == ST_IDLE && bus.start) || (state == ST_WRITE);
  assign lane_en    = (state == ST_MAC);
  assign bus.done   = (state == ST_DONE);
  assign bus.busy   = (state != ST_IDLE);
  assign dbg_state  = state;

  for (genvar n = 0; n < N; n++) begin : g_cout
    assign bus.c_out[n] = c_reg[n];
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [IW-1:0] b_idx;
    assign b_idx = IW'(int'(k) * N + int'(g) * LANES + l);
    mac_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (lane_clear),
      .en    (lane_en),
      .a     (a_reg[k]),
      .b     (bus.b_in[b_idx]),
      .acc   (lane_acc[l])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      k     <= '0;
      g     <= '0;
      for (int i = 0; i < K; i++) a_reg[i] <= '0;
      for (int i = 0; i < N; i++) c_reg[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            for (int i = 0; i < K; i++) a_reg[i] <= data_t'(bus.a_in[i]);
            k     <= '0;
            g     <= '0;
            state <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (k == K_LAST) begin
            k     <= '0;
            state <= ST_WRITE;
          end else begin
            k <= k + 1'b1;
          end
        end
        ST_WRITE: begin
          for (int l = 0; l < LANES; l++) c_reg[CW'(int'(g) * LANES + l)] <= lane_acc[l];
          if (g == G_LAST) begin
            state <= ST_DONE;
          end else begin
            g     <= g + 1'b1;
            state <= ST_MAC;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
